// File: rtl/bus_arbit_rr4_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
// Holds the master count, FSM state encoding and default tenure limit.
package bus_arbit_rr4_pkg;

  localparam int unsigned NUM_M         = 4;
  localparam int unsigned ID_W          = 2;
  localparam int unsigned MAX_BURST_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [NUM_M-1:0] mask_t;
  typedef logic [ID_W-1:0]  id_t;

  function automatic mask_t id2mask(input id_t id);
    mask_t m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bus_arbit_rr4_rr_pick4.sv
// Combinational round-robin picker: first eligible request scanning
// cyclically from last+1, optionally excluding one master.
module rr_pick4
  import bus_arbit_rr4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       excl_en,
  input  logic [1:0] excl_id,
  output logic       valid,
  output logic [1:0] id
);

  mask_t elig;
  id_t   cand;

  always_comb begin
    elig  = req & ~(excl_en ? id2mask(excl_id) : mask_t'('0));
    valid = 1'b0;
    id    = last;
    cand  = '0;
    // i == NUM_M wraps back to last itself, so it is scanned last
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      cand = last + id_t'(i);
      if (!valid && elig[cand]) begin
        valid = 1'b1;
        id    = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbit_rr4.sv
// Round-robin arbiter for four bus masters with bounded tenure under
// contention; registered one-hot grant, grant index and busy flag.
module bus_arbit_rr4
  import bus_arbit_rr4_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] m_req,
  output logic [3:0] m_grant,
  output logic [1:0] grant_id,
  output logic       bus_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  id_t              last, last_nxt;
  id_t              owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  mask_t            grant_d;
  logic             busy_d;
  logic             pick_valid;
  id_t              pick_id;

  // In GRANT the owner is always excluded: harmless on release (its
  // request is already low) and exactly what preemption needs.
  rr_pick4 u_pick (
    .req     (m_req),
    .last    (last),
    .excl_en (state == GRANT),
    .excl_id (grant_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = grant_id;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          owner_nxt = pick_id;
          last_nxt  = pick_id;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!m_req[grant_id] || (cnt == CNT_MAX && pick_valid)) begin
          if (pick_valid) begin
            owner_nxt = pick_id;
            last_nxt  = pick_id;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_nxt == GRANT);
    grant_d = busy_d ? id2mask(owner_nxt) : mask_t'('0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_grant  <= '0;
      grant_id <= '0;
      bus_busy <= 1'b0;
    end else begin
      m_grant  <= grant_d;
      grant_id <= owner_nxt;
      bus_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_arbit_rr4.sv
// Bench for bus_arbit_rr4: MAX_BURST=8 and MAX_BURST=1 instances share
// stimulus and are each compared every cycle against a tenure-count model.
module tb_bus_arbit_rr4;

  logic       clk;
  logic       reset_n;
  logic [3:0] m_req;
  logic [3:0] g8, g1;
  logic [1:0] id8, id1;
  logic       busy8, busy1;

  int n_chk = 0;
  int n_bad = 0;

  bit md_busy[2];
  int md_owner[2];
  int md_last[2];
  int md_ten[2];
  int md_mb[2] = '{8, 1};

  bus_arbit_rr4 #(.MAX_BURST(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .m_req(m_req),
    .m_grant(g8), .grant_id(id8), .bus_busy(busy8)
  );

  bus_arbit_rr4 #(.MAX_BURST(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .m_req(m_req),
    .m_grant(g1), .grant_id(id1), .bus_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [3:0] r, input int from);
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (from + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_reset(input int k);
    md_busy[k]  = 1'b0;
    md_owner[k] = 0;
    md_last[k]  = 3;
    md_ten[k]   = 0;
  endfunction

  // Tenure counted as plain number of cycles owned; handover when
  // the owner lets go, or when it has owned MAX_BURST cycles and others wait.
  function automatic void model_step(input int k, input logic [3:0] req);
    logic [3:0] others;
    int p;
    if (!md_busy[k]) begin
      p = rr_first(req, md_last[k]);
      if (p >= 0) begin
        md_busy[k] = 1'b1; md_owner[k] = p; md_last[k] = p; md_ten[k] = 1;
      end
    end else begin
      others = req;
      others[md_owner[k]] = 1'b0;
      if (!req[md_owner[k]] || (md_ten[k] >= md_mb[k] && others != 4'b0)) begin
        p = rr_first(others, md_owner[k]);
        if (p >= 0) begin
          md_owner[k] = p; md_last[k] = p; md_ten[k] = 1;
        end else begin
          md_busy[k] = 1'b0;
        end
      end else begin
        md_ten[k]++;
      end
    end
  endfunction

  function automatic logic [31:0] exp_grant(input int k);
    return md_busy[k] ? (32'd1 << md_owner[k]) : 32'd0;
  endfunction

  task automatic compare_all();
    chk("grant8", 32'(g8), exp_grant(0));
    chk("id8", 32'(id8), 32'(md_owner[0]));
    chk("busy8", 32'(busy8), 32'(md_busy[0]));
    chk("onehot8", 32'($onehot0(g8)), 32'd1);
    chk("grant1", 32'(g1), exp_grant(1));
    chk("id1", 32'(id1), 32'(md_owner[1]));
    chk("busy1", 32'(busy1), 32'(md_busy[1]));
    chk("onehot1", 32'($onehot0(g1)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset_n) model_step(k, m_req);
      else model_reset(k);
    end
    #1;
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0;
    m_req   = 4'b1111;
    model_reset(0);
    model_reset(1);

    // reset with everyone requesting
    repeat (3) cycle();
    chk("rst_grant", 32'(g8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_id", 32'(id8), 32'd0);
    reset_n = 1'b1;
    cycle();
    chk("first_grant", 32'(g8), 32'b0001);
    chk("first_id", 32'(id8), 32'd0);
    m_req = 4'b0000;
    cycle();

    // single requester hold
    m_req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("single_hold", 32'(g8), 32'b0100);
    end
    m_req = 4'b0000;
    cycle();
    chk("single_drop_grant", 32'(g8), 32'd0);
    chk("single_drop_id", 32'(id8), 32'd2);
    chk("single_drop_busy", 32'(busy8), 32'd0);

    // contention preempt, MAX_BURST=8
    m_req = 4'b0011;
    for (int i = 0; i < 24; i++) begin
      cycle();
      chk("preempt_grant", 32'(g8), 32'd1 << ((i / 8) % 2));
      chk("preempt_busy", 32'(busy8), 32'd1);
    end

    // early release handover from master 2 to master 0
    m_req = 4'b0100;
    cycle();
    chk("to_m2", 32'(g8), 32'b0100);
    m_req = 4'b0101;
    repeat (2) cycle();
    chk("m2_hold", 32'(g8), 32'b0100);
    m_req = 4'b0001;
    cycle();
    chk("release_grant", 32'(g8), 32'b0001);
    chk("release_busy", 32'(busy8), 32'd1);

    // full fairness on MAX_BURST=1 from a fresh pointer
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    m_req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("fair_id", 32'(id1), 32'(i % 4));
      chk("fair_grant", 32'(g1), 32'd1 << (i % 4));
    end

    // async reset while master 3 owns
    m_req = 4'b1000;
    cycle();
    chk("m3_owns", 32'(g8), 32'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("async_grant8", 32'(g8), 32'd0);
    chk("async_busy8", 32'(busy8), 32'd0);
    chk("async_grant1", 32'(g1), 32'd0);
    compare_all();
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("post_rst_grant", 32'(g8), 32'b1000);
    chk("post_rst_id", 32'(id8), 32'd3);

    // randomized traffic with sticky requests
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3) m_req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) m_req[$urandom_range(0, 3)] = ~m_req[$urandom_range(0, 3)];
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
